div_unit: RTL
=============

Name: div_unit

Overview:
- Iterative 64-bit integer divider for the execute stage.
- Consumes the rd1/rd2 operands and ALU function produced by decode for DIV/DIVU/REM/REMU and their W forms.
- Returns the quotient or remainder to the pipeline over a valid/ready handshake.
- Execute holds the instruction (stalls fetch/decode) while in_ready or out_valid says the unit is occupied.

Parameters:
- XLEN, 64, operand/result width.
- CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  decode presents a divide op.
- in_ready  out  1  unit is IDLE and can accept.
- alufunc  in  alufunc_t  DIV, DIVU, REM or REMU; other values are ignored.
- is_word  in  1  W variant; 32-bit semantics.
- a  in  XLEN  dividend (rd1).
- b  in  XLEN  divisor (rd2).
- flush  in  1  squash the in-flight op.
- out_valid  out  1  result available.
- out_ready  in  1  writeback consumes the result.
- result  out  XLEN  quotient or remainder, sign-extended for W.

Behaviour:
- Reset state (asynchronous, any cycle): state=IDLE, in_ready=1, out_valid=0, result=0, counter=0. Reset mid-operation discards the op.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Accept when in_valid && in_ready.
  - W ops use a[31:0] and b[31:0], sign- or zero-extended internally per alufunc; upper input bits are ignored.
  - Signed ops latch |a| and |b|, neg_q = sign(a)^sign(b), neg_r = sign(a).
- Special cases, resolved at accept and going straight to DONE (out_valid in cycle T+1, T = accept cycle):
  - b==0: quotient = all ones (W: 0xFFFFFFFF, then sign-extended); remainder = dividend (W: sext(a[31:0])).
  - Signed overflow (a = most-negative, b = -1): quotient = dividend, remainder = 0.
    - XLEN: a = 0x8000_0000_0000_0000.
    - W: a[31:0] = 0x8000_0000; quotient = 0xFFFF_FFFF_8000_0000.
- BUSY:
  - One restoring radix-2 step per cycle over a 2*XLEN {rem,quot} shift register; counter increments.
  - After N iterations go to DONE. N=64, except N=32 for W when DIV_W_FAST_EN is set.
  - Normal latency: out_valid first high in cycle T+N+1.
- DONE:
  - result = REM* ? remainder : quotient, negated when neg_q/neg_r applies.
  - W: result = sext(result[31:0]).
  - result is registered on entry to DONE and held stable while out_valid && !out_ready.
  - out_valid && out_ready -> IDLE. in_ready rises the next cycle; no same-cycle re-accept.
- flush:
  - In BUSY or DONE: state -> IDLE next edge, out_valid deasserts, no result is delivered.
  - In IDLE: blocks accept that cycle.
  - flush has priority over out_ready in the same cycle.
- Unsigned ops: no negation; full 64-bit unsigned range, e.g. DIVU 0xFFFF_FFFF_FFFF_FFFF / 1 = same value.

Optional Feature:
- Macro DIV_W_FAST_EN.
- Defined: W ops run 32 iterations on the low half only; latency T+33.
- Undefined: all ops run 64 iterations; W results are bit-identical either way.

Decomposition:
- Package pipes (shared):
  - div_state_t enum {IDLE,BUSY,DONE}.
  - constant DIV_ITERS=64.
  - constant DIV_ITERS_W=32.
  - reuse the existing alufunc_t.
- Sub-module div_core: combinational one-step shift/subtract/restore on {rem,quot}. It is instantiated once; div_unit owns the FSM, counter, sign fixup and handshake.

Test Plan:
- DIV a=100, b=7, accept T=0 -> out_valid first at cycle 65, result=14; REM same operands -> 2.
- DIV a=-7, b=2 -> 0xFFFF_FFFF_FFFF_FFFD; REM -> 0xFFFF_FFFF_FFFF_FFFF; REMU a=5, b=0 -> result=5 with out_valid at T+1.
- DIV a=0x8000_0000_0000_0000, b=-1 -> result=0x8000_0000_0000_0000, out_valid at T+1.
- DIVW a=0x1234_5678_FFFF_FFF9, b=2 -> 0xFFFF_FFFF_FFFF_FFFD, at T+65 (T+33 with DIV_W_FAST_EN).
- Flush at cycle 30 of BUSY -> in_ready=1 next cycle, out_valid never asserts; a new DIVU 9/3 then returns 3.
- Hold out_ready=0 for 3 cycles in DONE -> result and out_valid stable; resetn low mid-BUSY -> in_ready=1, out_valid=0 immediately (asynchronous).

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared pipeline types for the divider: FSM state encoding, iteration
// counts and the decode ALU function encoding.
package pipes;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_ITERS   = 64;
  localparam int DIV_ITERS_W = 32;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_SLTU = 5'd9,
    ALU_MUL  = 5'd10,
    ALU_DIV  = 5'd11,
    ALU_DIVU = 5'd12,
    ALU_REM  = 5'd13,
    ALU_REMU = 5'd14
  } alufunc_t;

  // True for the four functions this unit executes.
  function automatic logic is_div_op(alufunc_t f);
    return (f == ALU_DIV) || (f == ALU_DIVU) || (f == ALU_REM) || (f == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_unit_core.sv
// One restoring radix-2 division step on the {rem,quot} shift register.
// Purely combinational; the caller feeds back rem_o/quot_o each cycle.
module div_core
  import pipes::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quot_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quot_o
);

  // The shifted partial remainder needs one extra bit so the full unsigned
  // divisor range works; the top bit of the difference acts as the borrow.
  logic [XLEN:0] r_sh;
  logic [XLEN:0] diff;

  // Shift, trial-subtract, restore on borrow.
  always_comb begin
    r_sh = {rem_i, quot_i[XLEN-1]};
    diff = r_sh - {1'b0, divisor_i};
    if (!diff[XLEN]) begin
      rem_o  = diff[XLEN-1:0];
      quot_o = {quot_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o  = r_sh[XLEN-1:0];
      quot_o = {quot_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 64-bit integer divider (DIV/DIVU/REM/REMU and W forms).
// Handshake: an op is taken on a cycle where in_valid && in_ready && !flush
// and alufunc is a divide function; a result is consumed on a cycle where
// out_valid && out_ready && !flush. flush in BUSY/DONE drops the op.
// Optional macro DIV_W_FAST_EN: W ops run 32 iterations instead of 64.
module div_unit
  import pipes::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  alufunc_t        alufunc,
  input  logic            is_word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  div_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;
  logic            is_rem_q, is_rem_d;
  logic            word_q, word_d;

  logic            op_signed, op_rem, accept;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, quot_init, min_val;
  logic            a_neg, b_neg, div_by_zero, overflow;
  logic [XLEN-1:0] rem_n, quot_n, q_fix, r_fix, sel, special_val;
  logic [CNT_W-1:0] last_cnt;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

  // Operand preparation: W narrowing, absolute values, special-case detect.
  always_comb begin
    op_signed = (alufunc == ALU_DIV) || (alufunc == ALU_REM);
    op_rem    = (alufunc == ALU_REM) || (alufunc == ALU_REMU);
    accept    = in_valid && in_ready && !flush && is_div_op(alufunc);
    if (is_word) begin
      a_ext   = op_signed ? {{(XLEN-32){a[31]}}, a[31:0]} : {{(XLEN-32){1'b0}}, a[31:0]};
      b_ext   = op_signed ? {{(XLEN-32){b[31]}}, b[31:0]} : {{(XLEN-32){1'b0}}, b[31:0]};
      min_val = {{(XLEN-31){1'b1}}, {31{1'b0}}};
    end else begin
      a_ext   = a;
      b_ext   = b;
      min_val = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg       = op_signed && a_ext[XLEN-1];
    b_neg       = op_signed && b_ext[XLEN-1];
    a_abs       = a_neg ? (~a_ext + 1'b1) : a_ext;
    b_abs       = b_neg ? (~b_ext + 1'b1) : b_ext;
    div_by_zero = (b_ext == '0);
    overflow    = op_signed && (a_ext == min_val) && (b_ext == '1);
    // Zero divisor: quotient all ones, remainder the dividend.
    // Overflow: quotient the dividend, remainder zero.
    if (div_by_zero) special_val = op_rem ? a_ext : '1;
    else             special_val = op_rem ? '0 : a_ext;
    if (is_word) special_val = {{(XLEN-32){special_val[31]}}, special_val[31:0]};
`ifdef DIV_W_FAST_EN
    // Fast W mode starts the dividend at the top so 32 steps consume it.
    quot_init = is_word ? {a_abs[31:0], {(XLEN-32){1'b0}}} : a_abs;
`else
    quot_init = a_abs;
`endif
  end

`ifdef DIV_W_FAST_EN
  assign last_cnt = word_q ? CNT_W'(DIV_ITERS_W - 1) : CNT_W'(DIV_ITERS - 1);
`else
  assign last_cnt = CNT_W'(DIV_ITERS - 1);
`endif

  div_core #(.XLEN(XLEN)) u_core (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (dvsr_q),
    .rem_o     (rem_n),
    .quot_o    (quot_n)
  );

  // Sign fixup of the final step's outputs, then W sign extension.
  always_comb begin
    q_fix = neg_quot_q ? (~quot_n + 1'b1) : quot_n;
    r_fix = neg_rem_q  ? (~rem_n + 1'b1)  : rem_n;
    sel   = is_rem_q ? r_fix : q_fix;
    if (word_q) sel = {{(XLEN-32){sel[31]}}, sel[31:0]};
  end

  // FSM next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    result_d   = result_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    is_rem_d   = is_rem_q;
    word_d     = word_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          word_d     = is_word;
          is_rem_d   = op_rem;
          neg_quot_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          dvsr_d     = b_abs;
          quot_d     = quot_init;
          rem_d      = '0;
          cnt_d      = '0;
          if (div_by_zero || overflow) begin
            result_d = special_val;
            state_d  = DONE;
          end else begin
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          rem_d  = rem_n;
          quot_d = quot_n;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == last_cnt) begin
            result_d = sel;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (flush || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any op in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      result_q   <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_rem_q   <= 1'b0;
      word_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      result_q   <= result_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      is_rem_q   <= is_rem_d;
      word_q     <= word_d;
    end
  end

endmodule
